alu_multicycle: RTL and testbench

//  Execute-stage ALU that consumes the 4-bit ALUControl code from the ALU controller.
//  AND/OR/ADD/SUB/SLT complete in one cycle. MUL uses an iterative shift-add datapath,
//  one multiplier bit per clock. A Start/Busy/Done handshake lets the pipeline stall

---
 rtl/alu_multicycle.sv | 163 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with a single-cycle path for the logic,
// add/sub and compare codes, and an iterative shift-add multiplier that
// handles one multiplier bit per clock behind a start/busy/done handshake.
// Result and zero flag are registered and hold until the next completion.
//
// Build option: define MUL_EARLY_TERM_EN to stop a multiply once no set
// multiplier bits remain. A zero multiplier then completes in one cycle.
// Result values are identical with and without it.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready; a start launches a 1-cycle op or loads the multiplier
// ST_MUL  | shift-add iteration in flight, busy asserted
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [3:0]       i_alu_control,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_alu_result,
   output logic             o_zero,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_MUL = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd6;
   localparam logic [3:0] OP_SLT = 4'd7;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_next_state;

   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_done;

   logic [WIDTH-1:0] w_op_result;
   logic [WIDTH-1:0] w_step_sum;
   logic             w_accept;
   logic             w_is_mul;
   logic             w_mul_start;
   logic             w_mul_last;
   logic             w_mul_done;
   logic             w_single;
   logic             w_slt;

`ifndef MUL_EARLY_TERM_EN
   localparam int         CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
   // Iteration down-counter; the last iteration is the one seen at terminal count 0.
   logic [CW-1:0]    r_count;
`endif

   assign w_accept = (r_state == ST_IDLE) && i_start;
   assign w_is_mul = (i_alu_control == OP_MUL);
   assign w_slt    = ($signed(i_a) < $signed(i_b));

   // Only the low WIDTH product bits are kept, so the accumulator and the
   // shifted multiplicand can simply wrap at WIDTH bits.
   assign w_step_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef MUL_EARLY_TERM_EN
   assign w_mul_start = w_accept && w_is_mul && (i_b != '0);
   assign w_mul_last  = (r_mplier[WIDTH-1:1] == '0);
`else
   assign w_mul_start = w_accept && w_is_mul;
   assign w_mul_last  = (r_count == '0);
`endif

   assign w_mul_done = (r_state == ST_MUL) && w_mul_last;
   // Everything accepted that does not iterate (including a zero-multiplier
   // MUL in the early-terminating build) completes at the accepting edge.
   assign w_single   = w_accept && !w_mul_start;

   // Single-cycle operation result; a MUL only reaches here when its product is 0.
   always_comb begin
      w_op_result = '0;
      case (i_alu_control)
         OP_AND:  w_op_result = i_a & i_b;
         OP_OR:   w_op_result = i_a | i_b;
         OP_ADD:  w_op_result = i_a + i_b;
         OP_SUB:  w_op_result = i_a - i_b;
         OP_SLT:  w_op_result = {{(WIDTH-1){1'b0}}, w_slt};
         default: w_op_result = '0;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next_state;
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_mul_start) w_next_state = ST_MUL;
         ST_MUL:  if (w_mul_last)  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Operand capture, shift-add iteration and result/flag registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_done   <= 1'b0;
`ifndef MUL_EARLY_TERM_EN
         r_count  <= '0;
`endif
      end else begin
         r_done <= w_single || w_mul_done;
         if (w_single) begin
            r_result <= w_op_result;
            r_zero   <= (w_op_result == '0);
         end
         if (w_mul_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
`ifndef MUL_EARLY_TERM_EN
            r_count  <= CNT_LOAD;
`endif
         end else if (r_state == ST_MUL) begin
            r_acc    <= w_step_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
`ifndef MUL_EARLY_TERM_EN
            r_count  <= r_count - CW'(1);
`endif
            if (w_mul_last) begin
               r_result <= w_step_sum;
               r_zero   <= (w_step_sum == '0);
            end
         end
      end
   end

   assign o_alu_result = r_result;
   assign o_zero       = r_zero;
   assign o_busy       = (r_state == ST_MUL);
   assign o_done       = r_done;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=32). Latency expectations follow
// the MUL_EARLY_TERM_EN setting of the build.
module tb_alu_multicycle;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic         start;
   logic [3:0]   ctrl;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] result;
   logic         zero;
   logic         busy;
   logic         done;

   int errors = 0;
   int checks = 0;

   alu_multicycle #(.WIDTH(W)) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_start      (start),
      .i_alu_control(ctrl),
      .i_a          (a),
      .i_b          (b),
      .o_alu_result (result),
      .o_zero       (zero),
      .o_busy       (busy),
      .o_done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int t;
   int busy_cnt;
   int done_cnt;
   int exp_mul_lat;
   int exp_mul_busy;
   int exp_b0_lat;
   logic [W-1:0] res_at_done;

   initial begin
`ifdef MUL_EARLY_TERM_EN
      exp_mul_lat  = 4;
      exp_mul_busy = 3;
      exp_b0_lat   = 1;
`else
      exp_mul_lat  = 33;
      exp_mul_busy = 32;
      exp_b0_lat   = 33;
`endif
      rst = 1'b1; start = 1'b0; ctrl = 4'd0; a = '0; b = '0;
      #12;
      chk("rst_result", result, 32'd0);
      chk("rst_zero",   {31'd0, zero}, 32'd1);
      chk("rst_busy",   {31'd0, busy}, 32'd0);
      chk("rst_done",   {31'd0, done}, 32'd0);
      rst = 1'b0;
      tick();

      // ADD 5+7
      start = 1'b1; ctrl = 4'd2; a = 32'd5; b = 32'd7;
      tick();
      start = 1'b0;
      chk("add_done",   {31'd0, done}, 32'd1);
      chk("add_result", result, 32'd12);
      chk("add_zero",   {31'd0, zero}, 32'd0);
      chk("add_busy",   {31'd0, busy}, 32'd0);
      tick();
      chk("add_done_off", {31'd0, done}, 32'd0);

      // SUB 3-3, then SLT started on the Done cycle
      start = 1'b1; ctrl = 4'd6; a = 32'd3; b = 32'd3;
      tick();
      chk("sub_done",   {31'd0, done}, 32'd1);
      chk("sub_result", result, 32'd0);
      chk("sub_zero",   {31'd0, zero}, 32'd1);
      ctrl = 4'd7; a = 32'hFFFF_FFFF; b = 32'd1;
      tick();
      start = 1'b0;
      chk("slt_done",   {31'd0, done}, 32'd1);
      chk("slt_result", result, 32'd1);
      chk("slt_zero",   {31'd0, zero}, 32'd0);

      // Undefined control code
      start = 1'b1; ctrl = 4'd9; a = 32'h55; b = 32'h0F;
      tick();
      start = 1'b0;
      chk("undef_done",   {31'd0, done}, 32'd1);
      chk("undef_result", result, 32'd0);
      chk("undef_zero",   {31'd0, zero}, 32'd1);
      tick();

      // MUL 6*7, operands scrambled after capture
      start = 1'b1; ctrl = 4'd3; a = 32'd6; b = 32'd7;
      tick();
      start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
      t = 1; busy_cnt = 0;
      while (!done && t < 100) begin
         if (busy) busy_cnt++;
         tick();
         t++;
      end
      chk("mul_latency", t,        exp_mul_lat);
      chk("mul_busy",    busy_cnt, exp_mul_busy);
      chk("mul_result",  result,   32'd42);
      chk("mul_zero",    {31'd0, zero}, 32'd0);
      chk("mul_busy_at_done", {31'd0, busy}, 32'd0);
      tick();
      chk("mul_done_off", {31'd0, done}, 32'd0);

      // MUL -3*4
      start = 1'b1; ctrl = 4'd3; a = 32'hFFFF_FFFD; b = 32'd4;
      tick();
      start = 1'b0;
      t = 1;
      while (!done && t < 100) begin tick(); t++; end
      chk("mul_neg_result", result, 32'hFFFF_FFF4);
      tick();

      // MUL by zero
      start = 1'b1; ctrl = 4'd3; a = 32'd123; b = 32'd0;
      tick();
      start = 1'b0;
      t = 1;
      while (!done && t < 100) begin tick(); t++; end
      chk("mul_b0_latency", t, exp_b0_lat);
      chk("mul_b0_result",  result, 32'd0);
      chk("mul_b0_zero",    {31'd0, zero}, 32'd1);
      tick();

      // Start of an ADD while a MUL 9*5 is busy must be ignored
      start = 1'b1; ctrl = 4'd3; a = 32'd9; b = 32'd5;
      tick();
      ctrl = 4'd2; a = 32'd1; b = 32'd1;
      chk("ign_busy", {31'd0, busy}, 32'd1);
      tick();
      start = 1'b0;
      done_cnt = 0; res_at_done = '1;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            done_cnt++;
            res_at_done = result;
         end
         tick();
      end
      chk("ign_done_cnt", done_cnt, 32'd1);
      chk("ign_result",   res_at_done, 32'd45);

      // Reset during iteration 10 of a long multiply
      start = 1'b1; ctrl = 4'd3; a = 32'd6; b = 32'h8000_0007;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      chk("abort_busy_pre", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy",   {31'd0, busy}, 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_zero",   {31'd0, zero}, 32'd1);
      chk("abort_done",   {31'd0, done}, 32'd0);
      tick();
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) done_cnt++;
         tick();
      end
      chk("abort_no_done", done_cnt, 32'd0);

      // ADD 2+2 after the abort
      start = 1'b1; ctrl = 4'd2; a = 32'd2; b = 32'd2;
      tick();
      start = 1'b0;
      chk("post_add_done",   {31'd0, done}, 32'd1);
      chk("post_add_result", result, 32'd4);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
